// File: rtl/detector_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// detector_frame_scheduler_pkg
// Shared definitions for the detector frame scheduler:
//   - sched_state_t : scheduler FSM state encoding
//   - DEF_*         : default sizing constants used by the interface and top
// -----------------------------------------------------------------------------
package detector_frame_scheduler_pkg;

    localparam int DEF_N         = 4;
    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_COUNT_W   = 4;
    localparam int DEF_IDX_W     = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CLEAR,
        RUN,
        DRAIN,
        REPORT
    } sched_state_t;

endpackage

// File: rtl/detector_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// detector_frame_scheduler_if
// Bundles the channel-side, detector-side and result signals of the scheduler.
//   enable       : allow new grants
//   ch_req       : per-channel request (level)
//   ch_bit       : per-channel serial data
//   grant        : one-hot grant, held for the whole frame
//   det_x        : serial bit to the shared detector
//   det_start    : detector start
//   det_reset    : detector reset
//   det_z        : detector Moore output
//   busy         : scheduler not idle
//   result_valid : one-cycle result strobe
//   result_ch    : channel of the reported frame
//   result_count : saturated detection count of the reported frame
// Modports: master = scheduler side, slave = channel/detector environment.
// -----------------------------------------------------------------------------
interface detector_frame_scheduler_if
    import detector_frame_scheduler_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int IDX_W   = DEF_IDX_W
);
    logic               enable;
    logic [N-1:0]       ch_req;
    logic [N-1:0]       ch_bit;
    logic [N-1:0]       grant;
    logic               det_x;
    logic               det_start;
    logic               det_reset;
    logic               det_z;
    logic               busy;
    logic               result_valid;
    logic [IDX_W-1:0]   result_ch;
    logic [COUNT_W-1:0] result_count;

    modport master (
        input  enable, ch_req, ch_bit, det_z,
        output grant, det_x, det_start, det_reset, busy,
               result_valid, result_ch, result_count
    );

    modport slave (
        output enable, ch_req, ch_bit, det_z,
        input  grant, det_x, det_start, det_reset, busy,
               result_valid, result_ch, result_count
    );

endinterface

// File: rtl/detector_frame_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// detector_frame_scheduler_rr_arbiter
// Combinational round-robin pick: first requester at or after ptr, wrapping.
//   req : per-channel requests
//   ptr : highest-priority channel index
//   gnt : one-hot winner (zero when no request)
//   idx : winner index (zero when no request)
//   any : at least one request present
// -----------------------------------------------------------------------------
module detector_frame_scheduler_rr_arbiter
    import detector_frame_scheduler_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

    // One extra bit holds ptr+i before wrapping; ptr+i never exceeds 2N-2.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            pos = sum[IDX_W-1:0];
            if (!any && req[pos]) begin
                any      = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/moore_detector1101.sv
// -----------------------------------------------------------------------------
// moore_detector1101
// Overlapping Moore detector for the serial pattern 1,1,0,1.
//   x     : serial input bit, consumed when start is high
//   start : advance the detector; when low the state is held
//   reset : synchronous active-high reset to the empty-prefix state
//   clk   : clock
//   z     : high for one state after the final 1 of a match (registered)
// -----------------------------------------------------------------------------
module moore_detector1101 (
    input  logic x,
    input  logic start,
    input  logic reset,
    input  logic clk,
    output logic z
);

    // Each state names the longest suffix seen that is a prefix of 1101.
    typedef enum logic [2:0] {
        S0,
        S1,
        S11,
        S110,
        S1101
    } det_state_t;

    det_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else if (start) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = x ? S1   : S0;
            S1:      state_next = x ? S11  : S0;
            S11:     state_next = x ? S11  : S110;
            S110:    state_next = x ? S1101 : S0;
            S1101:   state_next = x ? S11  : S0;
            default: state_next = S0;
        endcase
    end

    assign z = (state == S1101);

endmodule

// File: rtl/detector_frame_scheduler.sv
// -----------------------------------------------------------------------------
// detector_frame_scheduler
// Shares one 1101 Moore detector among N serial channels. Grants requesters
// round-robin, clears the detector, streams FRAME_LEN bits of the granted
// channel, counts z-high cycles (saturating) and reports the count.
//   clock : system clock
//   reset : synchronous active-high reset
//   bus   : detector_frame_scheduler_if master modport (requests, data,
//           detector drive/return, busy and result outputs)
// -----------------------------------------------------------------------------
module detector_frame_scheduler
    import detector_frame_scheduler_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int COUNT_W   = DEF_COUNT_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                         clock,
    input  logic                         reset,
    detector_frame_scheduler_if.master   bus
);

    localparam int                 BIT_W    = $clog2(FRAME_LEN);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]   LAST_CH  = IDX_W'(N - 1);

    sched_state_t       state, state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel;
    logic [N-1:0]       grant_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [COUNT_W-1:0] hit_cnt;
    logic [COUNT_W-1:0] hit_next;
    logic [IDX_W-1:0]   res_ch;
    logic [COUNT_W-1:0] res_count;
    logic               want_frame;

    logic [N-1:0]       arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    detector_frame_scheduler_rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (bus.ch_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign want_frame = bus.enable && (|bus.ch_req);

    // Saturating hit increment; also used in DRAIN so the final z sample
    // lands in the reported count on the same edge.
    assign hit_next = (bus.det_z && (hit_cnt != '1)) ? hit_cnt + COUNT_W'(1) : hit_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (want_frame) state_next = ARB;
            ARB:     state_next = arb_any ? CLEAR : IDLE;
            CLEAR:   state_next = RUN;
            RUN:     if (bit_cnt == LAST_BIT) state_next = DRAIN;
            DRAIN:   state_next = REPORT;
            REPORT:  state_next = want_frame ? ARB : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state; reset overrides so the
    // detector is held cleared and nothing is reported while it is high.
    always_comb begin
        bus.det_reset    = reset || (state == CLEAR);
        bus.det_start    = !reset && ((state == RUN) || (state == DRAIN));
        bus.det_x        = !reset && (state == RUN) && bus.ch_bit[sel];
        bus.busy         = !reset && (state != IDLE);
        bus.result_valid = !reset && (state == REPORT);
        bus.grant        = grant_q;
        bus.result_ch    = res_ch;
        bus.result_count = res_count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= '0;
            sel       <= '0;
            grant_q   <= '0;
            bit_cnt   <= '0;
            hit_cnt   <= '0;
            res_ch    <= '0;
            res_count <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (arb_any) begin
                        sel     <= arb_idx;
                        grant_q <= arb_gnt;
                    end
                end
                CLEAR: begin
                    bit_cnt <= '0;
                    hit_cnt <= '0;
                end
                RUN: begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    hit_cnt <= hit_next;
                end
                DRAIN: begin
                    hit_cnt   <= hit_next;
                    res_ch    <= sel;
                    res_count <= hit_next;
                end
                REPORT: begin
                    rr_ptr  <= (sel == LAST_CH) ? '0 : sel + IDX_W'(1);
                    grant_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_detector_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_detector_frame_scheduler
// Directed bench for detector_frame_scheduler. Two scheduler instances share
// the same channel inputs: one with a 4-bit count and one with a 1-bit count
// (for saturation), each wired to its own moore_detector1101.
// -----------------------------------------------------------------------------
module tb_detector_frame_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] ch_req;
    logic [3:0] ch_bit;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    detector_frame_scheduler_if #(.N(4), .COUNT_W(4), .IDX_W(2)) bus_main ();
    detector_frame_scheduler_if #(.N(4), .COUNT_W(1), .IDX_W(2)) bus_sat ();

    assign bus_main.enable = enable;
    assign bus_main.ch_req = ch_req;
    assign bus_main.ch_bit = ch_bit;
    assign bus_sat.enable  = enable;
    assign bus_sat.ch_req  = ch_req;
    assign bus_sat.ch_bit  = ch_bit;

    detector_frame_scheduler #(.N(4), .FRAME_LEN(8), .COUNT_W(4), .IDX_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_main)
    );

    detector_frame_scheduler #(.N(4), .FRAME_LEN(8), .COUNT_W(1), .IDX_W(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus_sat)
    );

    moore_detector1101 u_det_main (
        .x     (bus_main.det_x),
        .start (bus_main.det_start),
        .reset (bus_main.det_reset),
        .clk   (clock),
        .z     (bus_main.det_z)
    );

    moore_detector1101 u_det_sat (
        .x     (bus_sat.det_x),
        .start (bus_sat.det_start),
        .reset (bus_sat.det_reset),
        .clk   (clock),
        .z     (bus_sat.det_z)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] req, input logic [3:0] bits);
        reset  = rst;
        enable = en;
        ch_req = req;
        ch_bit = bits;
    endtask

    // Entered one step after the edge that put the scheduler in ARB; leaves
    // one step after the REPORT cycle. Other channels carry the inverted
    // stream so a wrong channel select changes the count.
    task automatic runFrame(input int ch, input logic [7:0] stream, input int exp_count,
                            input int exp_sat, input logic [3:0] req_during, input logic en_during);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << ch;

        checkOutput($sformatf("ch%0d_arb_busy", ch), 32'(bus_main.busy), 1);
        checkOutput($sformatf("ch%0d_arb_grant", ch), 32'(bus_main.grant), 0);
        checkOutput($sformatf("ch%0d_arb_valid", ch), 32'(bus_main.result_valid), 0);
        stepClock();

        checkOutput($sformatf("ch%0d_clear_grant", ch), 32'(bus_main.grant), 32'(one_hot));
        checkOutput($sformatf("ch%0d_clear_det_reset", ch), 32'(bus_main.det_reset), 1);
        checkOutput($sformatf("ch%0d_clear_det_start", ch), 32'(bus_main.det_start), 0);
        stepClock();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, en_during, req_during, stream[3'(i)] ? one_hot : ~one_hot);
            #1;
            checkOutput($sformatf("ch%0d_run%0d_det_x", ch, i), 32'(bus_main.det_x), 32'(stream[3'(i)]));
            checkOutput($sformatf("ch%0d_run%0d_det_start", ch, i), 32'(bus_main.det_start), 1);
            checkOutput($sformatf("ch%0d_run%0d_grant", ch, i), 32'(bus_main.grant), 32'(one_hot));
            checkOutput($sformatf("ch%0d_run%0d_valid", ch, i), 32'(bus_main.result_valid), 0);
            stepClock();
        end

        ch_bit = 4'b1111;
        #1;
        checkOutput($sformatf("ch%0d_drain_det_x", ch), 32'(bus_main.det_x), 0);
        checkOutput($sformatf("ch%0d_drain_det_start", ch), 32'(bus_main.det_start), 1);
        checkOutput($sformatf("ch%0d_drain_valid", ch), 32'(bus_main.result_valid), 0);
        checkOutput($sformatf("ch%0d_drain_grant", ch), 32'(bus_main.grant), 32'(one_hot));
        stepClock();

        checkOutput($sformatf("ch%0d_report_valid", ch), 32'(bus_main.result_valid), 1);
        checkOutput($sformatf("ch%0d_report_ch", ch), 32'(bus_main.result_ch), 32'(ch));
        checkOutput($sformatf("ch%0d_report_count", ch), 32'(bus_main.result_count), 32'(exp_count));
        checkOutput($sformatf("ch%0d_report_grant", ch), 32'(bus_main.grant), 32'(one_hot));
        checkOutput($sformatf("ch%0d_sat_valid", ch), 32'(bus_sat.result_valid), 1);
        checkOutput($sformatf("ch%0d_sat_count", ch), 32'(bus_sat.result_count), 32'(exp_sat));
        stepClock();
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'b0000);

        // Reset held for three cycles with every channel requesting.
        for (int c = 0; c < 3; c++) begin
            stepClock();
            checkOutput($sformatf("rst%0d_grant", c), 32'(bus_main.grant), 0);
            checkOutput($sformatf("rst%0d_busy", c), 32'(bus_main.busy), 0);
            checkOutput($sformatf("rst%0d_det_reset", c), 32'(bus_main.det_reset), 1);
            checkOutput($sformatf("rst%0d_valid", c), 32'(bus_main.result_valid), 0);
            checkOutput($sformatf("rst%0d_det_start", c), 32'(bus_main.det_start), 0);
        end
        checkOutput("rst_result_ch", 32'(bus_main.result_ch), 0);
        checkOutput("rst_result_count", 32'(bus_main.result_count), 0);

        // All channels requesting, zero data on the granted channel: strict
        // rotation 0,1,2,3,0 with back-to-back 12-cycle frames. Enable drops
        // during the fifth frame, which still completes and reports.
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        stepClock();
        runFrame(0, 8'h00, 0, 0, 4'b1111, 1'b1);
        runFrame(1, 8'h00, 0, 0, 4'b1111, 1'b1);
        runFrame(2, 8'h00, 0, 0, 4'b1111, 1'b1);
        runFrame(3, 8'h00, 0, 0, 4'b1111, 1'b1);
        runFrame(0, 8'h00, 0, 0, 4'b1111, 1'b0);
        checkOutput("en_low_idle_busy", 32'(bus_main.busy), 0);
        stepClock();
        checkOutput("en_low_still_idle", 32'(bus_main.busy), 0);
        checkOutput("en_low_grant", 32'(bus_main.grant), 0);

        // Only ch1 requests, stream 1,1,0,1,1,0,1,0: two overlapping hits,
        // saturating to 1 in the 1-bit instance. Request drops mid-frame.
        applyStimulus(1'b0, 1'b1, 4'b0010, 4'b0000);
        stepClock();
        runFrame(1, 8'b0101_1011, 2, 1, 4'b0000, 1'b1);
        checkOutput("ch1_after_busy", 32'(bus_main.busy), 0);
        checkOutput("ch1_hold_ch", 32'(bus_main.result_ch), 1);
        checkOutput("ch1_hold_count", 32'(bus_main.result_count), 2);
        checkOutput("ch1_hold_valid", 32'(bus_main.result_valid), 0);

        // Pattern in the last four bits (0,0,0,0,1,1,0,1): the hit is only
        // visible in DRAIN. Ch3 keeps requesting so it is re-granted.
        applyStimulus(1'b0, 1'b1, 4'b1000, 4'b0000);
        stepClock();
        runFrame(3, 8'b1011_0000, 1, 1, 4'b1000, 1'b1);

        // Re-granted ch3 frame aborted by reset at RUN bit 5.
        checkOutput("regrant_busy", 32'(bus_main.busy), 1);
        stepClock();
        checkOutput("regrant_grant", 32'(bus_main.grant), 32'(4'b1000));
        stepClock();
        for (int i = 0; i < 5; i++) begin
            ch_bit = (i == 2) ? 4'b0000 : 4'b1000;
            stepClock();
        end
        applyStimulus(1'b1, 1'b1, 4'b1000, 4'b1000);
        #1;
        checkOutput("midrst_det_reset", 32'(bus_main.det_reset), 1);
        checkOutput("midrst_det_start", 32'(bus_main.det_start), 0);
        checkOutput("midrst_valid", 32'(bus_main.result_valid), 0);
        stepClock();
        checkOutput("midrst_grant", 32'(bus_main.grant), 0);
        checkOutput("midrst_busy", 32'(bus_main.busy), 0);
        checkOutput("midrst_valid_after", 32'(bus_main.result_valid), 0);
        checkOutput("midrst_count", 32'(bus_main.result_count), 0);
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'b0000);
        stepClock();
        checkOutput("midrst_hold_busy", 32'(bus_main.busy), 0);

        // After release the first grant goes to ch0; stream 1,1,1,0,1,0,0,0.
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        stepClock();
        runFrame(0, 8'b0001_0111, 1, 1, 4'b0000, 1'b1);
        checkOutput("final_busy", 32'(bus_main.busy), 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
